route_buffer_unit: RTL

Buffered, parametrised successor to the combinational XY routing decoder. It accepts flits into an input FIFO, computes the XY route for the head flit and holds a registered one-hot output request. The flit stays presented until the downstream arbiter grants it. It sits between a router input channel and the crossbar/output arbiters of a mesh node.

---
 rtl/route_pkg.sv | 31 +++
 rtl/flit_fifo.sv | 71 +++++++
 rtl/route_buffer_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/route_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : route_pkg
//  Description : Shared header-field positions, port indices and output-stage
//                state encoding for the buffered XY route unit.
//  Revision    : 1.0
// ============================================================================
package route_pkg;

    // Header bit positions; field widths come from HOP_W / COORD_W.
    localparam int c_dir_x_bit = 62;
    localparam int c_dir_y_bit = 61;
    localparam int c_hop_x_lsb = 52;
    localparam int c_hop_y_lsb = 48;
    localparam int c_src_x_lsb = 40;
    localparam int c_src_y_lsb = 32;

    localparam int c_port_l    = 0;
    localparam int c_port_r    = 1;
    localparam int c_port_u    = 2;
    localparam int c_port_d    = 3;
    localparam int c_port_pe   = 4;
    localparam int c_num_ports = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } out_state_t;

endpackage
`default_nettype wire

// File: rtl/flit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : flit_fifo
//  Description : Synchronous show-ahead FIFO; rdata is the head entry whenever
//                o_empty is low. Simultaneous push and pop keep the count.
//  Revision    : 1.0
// ============================================================================
module flit_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [DATA_WIDTH-1:0]         i_wdata,
    input  logic                          i_pop,
    output logic [DATA_WIDTH-1:0]         o_rdata,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int                 c_aw       = $clog2(FIFO_DEPTH);
    localparam logic [c_aw-1:0]    c_ptr_one  = (c_aw)'(1);
    localparam logic [c_aw:0]      c_cnt_one  = (c_aw+1)'(1);
    localparam logic [c_aw:0]      c_full_cnt = (c_aw+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]       r_wptr;
    logic [c_aw-1:0]       r_rptr;
    logic [c_aw:0]         r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_full  = (r_count == c_full_cnt);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    // Writes into a full FIFO and reads from an empty one are dropped here.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop  & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/route_buffer_unit.sv
`default_nettype none
// ============================================================================
//  Module      : route_buffer_unit
//  Description : Input FIFO feeding a registered XY-route request stage; the
//                head flit is held on out_req/out_data until granted.
//  Revision    : 1.0
// ============================================================================
module route_buffer_unit
    import route_pkg::*;
#(
    parameter int                 DATA_WIDTH = 64,
    parameter int                 COORD_W    = 8,
    parameter int                 HOP_W      = 4,
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [COORD_W-1:0] CUR_X      = '0,
    parameter logic [COORD_W-1:0] CUR_Y      = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_data,
    output logic [4:0]                  out_req,
    input  logic [4:0]                  out_gnt,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    // Sums wrap modulo 2^COORD_W; the left/down case compares mirrored.
    function automatic logic [c_num_ports-1:0] route_decode(
        input logic               dir_x,
        input logic               dir_y,
        input logic [COORD_W-1:0] hop_x,
        input logic [COORD_W-1:0] hop_y,
        input logic [COORD_W-1:0] src_x,
        input logic [COORD_W-1:0] src_y
    );
        logic [c_num_ports-1:0] req;
        logic [COORD_W-1:0]     sum_x;
        logic [COORD_W-1:0]     sum_y;
        logic                   x_done;
        logic                   y_done;
        req    = '0;
        sum_x  = dir_x ? (src_x + hop_x) : (CUR_X + hop_x);
        sum_y  = dir_y ? (src_y + hop_y) : (CUR_Y + hop_y);
        x_done = dir_x ? (sum_x == CUR_X) : (sum_x == src_x);
        y_done = dir_y ? (sum_y == CUR_Y) : (sum_y == src_y);
        if (!x_done) begin
            req[dir_x ? c_port_r : c_port_l] = 1'b1;
        end else if (!y_done) begin
            req[dir_y ? c_port_u : c_port_d] = 1'b1;
        end else begin
            req[c_port_pe] = 1'b1;
        end
        return req;
    endfunction

    logic [DATA_WIDTH-1:0]  w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_consume;
    logic [c_num_ports-1:0] w_head_req;

    out_state_t             r_state;
    logic [c_num_ports-1:0] r_out_req;
    logic [DATA_WIDTH-1:0]  r_out_data;

    flit_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (in_valid),
        .i_wdata (in_data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    assign w_head_req = route_decode(
        w_head[c_dir_x_bit],
        w_head[c_dir_y_bit],
        COORD_W'(w_head[c_hop_x_lsb +: HOP_W]),
        COORD_W'(w_head[c_hop_y_lsb +: HOP_W]),
        w_head[c_src_x_lsb +: COORD_W],
        w_head[c_src_y_lsb +: COORD_W]
    );

    // Only a grant bit matching the held request retires the flit.
    assign w_consume = (r_state == HOLD) && ((out_gnt & r_out_req) != '0);
    assign w_pop     = ~w_empty && ((r_state == IDLE) || w_consume);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_out_req  <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_out_req  <= w_head_req;
                        r_out_data <= w_head;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_consume) begin
                        if (!w_empty) begin
                            r_out_req  <= w_head_req;
                            r_out_data <= w_head;
                        end else begin
                            r_out_req  <= '0;
                            r_out_data <= '0;
                            r_state    <= IDLE;
                        end
                    end
                end
                default: begin
                    r_out_req  <= '0;
                    r_out_data <= '0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready = ~w_full;
    assign out_req  = r_out_req;
    assign out_data = r_out_data;

endmodule
`default_nettype wire
